// File: rtl/eco32f_mem_pkg.sv
// eco32f memory stage: shared types.
// LSU length codes, stage FSM states and the pipe register bundle.
package eco32f_mem_pkg;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'b00,
    LEN_HALF = 2'b01,
    LEN_WORD = 2'b10,
    LEN_RSVD = 2'b11
  } lsu_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } mem_st_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic        load;
    logic [1:0]  len;
    logic        sext;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic        align;
  } mem_pipe_t;

  // reserved length behaves as word
  function automatic logic misaligned(
    input logic [1:0] len,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (1'b1)
      len == LEN_BYTE: m = 1'b0;
      len == LEN_HALF: m = off[0];
      default:         m = |off;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/eco32f_mem_if.sv
// eco32f data bus: one request held until ack or err.
// Master is the memory stage, slave is the memory/bridge.
interface eco32f_mem_if;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  bsel;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack;
  logic        err;

  modport master (
    output req, we, adr, bsel, dat_o,
    input  dat_i, ack, err
  );

  modport slave (
    input  req, we, adr, bsel, dat_o,
    output dat_i, ack, err
  );
endinterface

// File: rtl/eco32f_mem_lsu_align.sv
// eco32f LSU lane logic: big-endian byte enables,
// store replication and load align/extend.
module eco32f_mem_lsu_align
  import eco32f_mem_pkg::*;
(
  input  logic [1:0]  st_len,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_bsel,
  output logic [31:0] st_rep,
  input  logic [1:0]  ld_len,
  input  logic [1:0]  ld_off,
  input  logic        ld_sext,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    st_bsel = 4'b1111;
    st_rep  = st_data;
    unique case (1'b1)
      st_len == LEN_BYTE: begin
        st_bsel = 4'b1000 >> st_off;
        st_rep  = {4{st_data[7:0]}};
      end
      st_len == LEN_HALF: begin
        st_bsel = st_off[1] ? 4'b0011 : 4'b1100;
        st_rep  = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // offset 0 lives in the top byte lane
  always_comb begin
    b = ld_raw[31:24];
    unique case (ld_off)
      2'd0: b = ld_raw[31:24];
      2'd1: b = ld_raw[23:16];
      2'd2: b = ld_raw[15:8];
      2'd3: b = ld_raw[7:0];
    endcase
    h = ld_off[1] ? ld_raw[15:0] : ld_raw[31:16];
    ld_data = ld_raw;
    unique case (1'b1)
      ld_len == LEN_BYTE:
        ld_data = {{24{ld_sext & b[7]}}, b};
      ld_len == LEN_HALF:
        ld_data = {{16{ld_sext & h[15]}}, h};
      default: ;
    endcase
  end
endmodule

// File: rtl/eco32f_mem.sv
// eco32f memory stage: pipe register, one bus access per
// load/store, load alignment and stall until the bus completes.
module eco32f_mem
  import eco32f_mem_pkg::*;
#(
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_valid,
  input  logic [31:0] exe_alu_result,
  input  logic        exe_op_load,
  input  logic        exe_op_store,
  input  logic [1:0]  exe_lsu_len,
  input  logic        exe_lsu_sext,
  input  logic [31:0] exe_store_data,
  input  logic        exe_rf_r_we,
  input  logic [4:0]  exe_rf_r_addr,
  input  logic        pipe_flush,
  eco32f_mem_if.master dbus,
  output logic        mem_stall,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_lsu_result,
  output logic        mem_op_load,
  output logic        mem_rf_r_we,
  output logic [4:0]  mem_rf_r_addr,
  output logic        mem_except_align,
  output logic        mem_except_bus
);
  mem_st_e     state_q, state_d;
  mem_pipe_t   pipe_q, pipe_d;
  logic        flushed_q;
  logic        bus_err_q;
  logic [31:0] lsu_q;
  logic        exe_ls, exe_mis;
  logic        launch, done;
  logic [3:0]  st_bsel;
  logic [31:0] st_rep, ld_data;

  assign mem_stall = (state_q == ST_WAIT);
  assign exe_ls = exe_valid & ~pipe_flush
                & (exe_op_load | exe_op_store);
  assign exe_mis = ALIGN_CHECK
                 & misaligned(exe_lsu_len,
                              exe_alu_result[1:0]);
  assign launch = ~mem_stall & exe_ls & ~exe_mis;
  assign done = mem_stall & (dbus.ack | dbus.err);

  eco32f_mem_lsu_align u_align (
    .st_len  (exe_lsu_len),
    .st_off  (exe_alu_result[1:0]),
    .st_data (exe_store_data),
    .st_bsel (st_bsel),
    .st_rep  (st_rep),
    .ld_len  (pipe_q.len),
    .ld_off  (pipe_q.alu[1:0]),
    .ld_sext (pipe_q.sext),
    .ld_raw  (dbus.dat_i),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT: if (done) state_d = ST_DONE;
      default: state_d = launch ? ST_WAIT : ST_IDLE;
    endcase
  end

  always_comb begin
    pipe_d = pipe_q;
    if (!mem_stall) begin
      pipe_d = '0;
      if (exe_valid && !pipe_flush) begin
        pipe_d.valid   = 1'b1;
        pipe_d.alu     = exe_alu_result;
        pipe_d.load    = exe_op_load;
        pipe_d.len     = exe_lsu_len;
        pipe_d.sext    = exe_lsu_sext;
        pipe_d.rf_we   = exe_rf_r_we;
        pipe_d.rf_addr = exe_rf_r_addr;
        pipe_d.align   = exe_mis
                       & (exe_op_load | exe_op_store);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q     <= '0;
      flushed_q  <= 1'b0;
      bus_err_q  <= 1'b0;
      lsu_q      <= '0;
      dbus.req   <= 1'b0;
      dbus.we    <= 1'b0;
      dbus.adr   <= '0;
      dbus.bsel  <= '0;
      dbus.dat_o <= '0;
    end else begin
      pipe_q <= pipe_d;
      // a flush while waiting only marks the access dead
      flushed_q <= mem_stall & (flushed_q | pipe_flush);
      if (!mem_stall) bus_err_q <= 1'b0;
      else if (done)  bus_err_q <= dbus.err;
      if (launch) begin
        dbus.req   <= 1'b1;
        dbus.we    <= exe_op_store;
        dbus.adr   <= {exe_alu_result[31:2], 2'b00};
        dbus.bsel  <= st_bsel;
        dbus.dat_o <= st_rep;
      end else if (done) begin
        dbus.req <= 1'b0;
        lsu_q    <= ld_data;
      end
    end
  end

  assign mem_alu_result = pipe_q.alu;
  assign mem_lsu_result = lsu_q;
  assign mem_rf_r_addr  = pipe_q.rf_addr;
  assign mem_op_load = pipe_q.valid & pipe_q.load
                     & ~pipe_q.align & ~mem_stall
                     & ~flushed_q;
  assign mem_rf_r_we = pipe_q.valid & pipe_q.rf_we
                     & ~pipe_q.align & ~bus_err_q
                     & ~flushed_q;
  assign mem_except_align = pipe_q.valid & pipe_q.align
                          & ~flushed_q;
  assign mem_except_bus = pipe_q.valid & bus_err_q
                        & ~flushed_q;
endmodule
